// File: rtl/conv_maxpool_relu_pkg.sv
// Shared definitions for the FP16 max-pool/ReLU stage: constants, FSM encoding
// and the FP16 total-order key used by the max comparator.
package conv_maxpool_relu_pkg;

    localparam logic [15:0] FP16_ZERO     = 16'h0000;
    localparam int          FP16_SIGN_BIT = 15;
    localparam int          POOL          = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Maps an FP16 pattern onto an unsigned key whose order matches the float order
    // (negatives reversed below positives, so -0 sits just under +0).
    function automatic logic [15:0] fp16_key(input logic [15:0] x);
        fp16_key = x[FP16_SIGN_BIT] ? ~x : (x ^ 16'h8000);
    endfunction

endpackage

// File: rtl/conv_maxpool_relu_fp16_max.sv
// Combinational two-input FP16 maximum; on equal keys the 'a' operand wins,
// so callers pass the running maximum on 'a'.
module fp16_max
    import conv_maxpool_relu_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    // Select the operand with the larger order key.
    always_comb begin
        if (fp16_key(b) > fp16_key(a)) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/conv_maxpool_relu.sv
// Sequential 2x2 stride-2 FP16 max-pooling with optional ReLU: one element is
// folded into the running maximum per clock, one output slot written per window.
module conv_maxpool_relu
    import conv_maxpool_relu_pkg::*;
#(
    parameter int H    = 28,
    parameter int W    = 28,
    parameter int DW   = 16,
    parameter int RELU = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [H*W*DW-1:0]              inputConv,
    output logic [(H/2)*(W/2)*DW-1:0]      outputPool,
    output logic                           busy,
    output logic                           done
);

    localparam int OH = H / POOL;
    localparam int OW = W / POOL;
    localparam int IW = (OH > 1) ? $clog2(OH) : 1;
    localparam int JW = (OW > 1) ? $clog2(OW) : 1;

    state_t          state_r;
    logic [IW-1:0]   i_r;
    logic [JW-1:0]   j_r;
    logic [1:0]      p_r;
    logic [DW-1:0]   max_r;

    int              elem_idx_s;
    int              slot_idx_s;
    logic [DW-1:0]   elem_s;
    logic [DW-1:0]   fmax_s;
    logic [DW-1:0]   pooled_s;

    // Element mux: p[1] selects the window row, p[0] the window column.
    always_comb begin
        elem_idx_s = (int'(i_r) * POOL + int'(p_r[1])) * W + int'(j_r) * POOL + int'(p_r[0]);
        slot_idx_s = int'(i_r) * OW + int'(j_r);
        elem_s     = inputConv[elem_idx_s*DW +: DW];
    end

    fp16_max u_fp16_max (
        .a (max_r),
        .b (elem_s),
        .y (fmax_s)
    );

    // ReLU acts only on the value written out, never on the running maximum.
    always_comb begin
        if ((RELU != 0) && fmax_s[FP16_SIGN_BIT]) begin
            pooled_s = FP16_ZERO;
        end else begin
            pooled_s = fmax_s;
        end
    end

    // Control FSM, window/phase counters and output slot register array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= IDLE;
            i_r        <= '0;
            j_r        <= '0;
            p_r        <= 2'd0;
            max_r      <= '0;
            outputPool <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r <= RUN;
                        busy    <= 1'b1;
                        i_r     <= '0;
                        j_r     <= '0;
                        p_r     <= 2'd0;
                    end else begin
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    if (p_r == 2'd0) begin
                        max_r <= elem_s;
                    end else begin
                        max_r <= fmax_s;
                    end
                    if (p_r == 2'd3) begin
                        outputPool[slot_idx_s*DW +: DW] <= pooled_s;
                        p_r <= 2'd0;
                        if (j_r == JW'(OW - 1)) begin
                            j_r <= '0;
                            if (i_r == IW'(OH - 1)) begin
                                i_r     <= '0;
                                state_r <= DONE;
                                busy    <= 1'b0;
                            end else begin
                                i_r <= i_r + IW'(1);
                            end
                        end else begin
                            j_r <= j_r + JW'(1);
                        end
                    end else begin
                        p_r <= p_r + 2'd1;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_maxpool_relu.sv
// Randomized and directed bench for conv_maxpool_relu: two 4x4 instances (RELU off/on)
// and one default 28x28 instance, checked against a float-order pooling model.
module tb_conv_maxpool_relu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 start4;
    logic                 start28;
    logic [4*4*16-1:0]    in4;
    logic [28*28*16-1:0]  in28;
    logic [2*2*16-1:0]    out_a;
    logic [2*2*16-1:0]    out_b;
    logic [14*14*16-1:0]  out_c;
    logic                 busy_a, busy_b, busy_c;
    logic                 done_a, done_b, done_c;

    conv_maxpool_relu #(.H(4), .W(4), .DW(16), .RELU(0)) dut_a (
        .clk(clk), .reset(reset), .start(start4), .inputConv(in4),
        .outputPool(out_a), .busy(busy_a), .done(done_a));

    conv_maxpool_relu #(.H(4), .W(4), .DW(16), .RELU(1)) dut_b (
        .clk(clk), .reset(reset), .start(start4), .inputConv(in4),
        .outputPool(out_b), .busy(busy_b), .done(done_b));

    conv_maxpool_relu dut_c (
        .clk(clk), .reset(reset), .start(start28), .inputConv(in28),
        .outputPool(out_c), .busy(busy_c), .done(done_c));

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] img [784];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Float ordering: negative magnitudes mirrored below zero, -0 just under +0.
    function automatic int fp_ord(input logic [15:0] x);
        int mag;
        mag = int'(x[14:0]);
        return x[15] ? (-1 - mag) : mag;
    endfunction

    function automatic logic [15:0] exp_slot(input int w, input int i, input int j, input bit relu);
        logic [15:0] e [4];
        logic [15:0] m;
        e[0] = img[(2*i)*w + 2*j];
        e[1] = img[(2*i)*w + 2*j + 1];
        e[2] = img[(2*i+1)*w + 2*j];
        e[3] = img[(2*i+1)*w + 2*j + 1];
        m = e[0];
        for (int k = 1; k < 4; k++) if (fp_ord(e[k]) > fp_ord(m)) m = e[k];
        if (relu && m[15]) m = 16'h0000;
        return m;
    endfunction

    task automatic fill_rand(input int n);
        for (int k = 0; k < n; k++) img[k] = 16'($urandom);
    endtask

    task automatic run4(input string tag);
        int lat;
        int bcnt;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) in4[k*16 +: 16] = img[k];
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat  = 0;
        bcnt = busy_a ? 1 : 0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy_a) bcnt++;
            if (done_a) seen = 1'b1;
        end
        check_eq({tag, " latency"}, lat, 17);
        check_eq({tag, " busy cycles"}, bcnt, 16);
        check_eq({tag, " done relu inst"}, {31'd0, done_b}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check_eq({tag, " slot relu0"}, {16'd0, out_a[(i*2+j)*16 +: 16]}, {16'd0, exp_slot(4, i, j, 1'b0)});
                check_eq({tag, " slot relu1"}, {16'd0, out_b[(i*2+j)*16 +: 16]}, {16'd0, exp_slot(4, i, j, 1'b1)});
            end
        end
        @(negedge clk);
        check_eq({tag, " done one cycle"}, {31'd0, done_a}, 32'd0);
    endtask

    task automatic run28(input string tag, input int restart_at, input int reset_at);
        int lat;
        int bcnt;
        int nz;
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 784; k++) in28[k*16 +: 16] = img[k];
        start28 = 1'b1;
        @(negedge clk);
        start28 = 1'b0;
        lat  = 0;
        bcnt = busy_c ? 1 : 0;
        while (!seen && lat < 1000) begin
            @(negedge clk);
            lat++;
            start28 = (lat == restart_at);
            if (lat == reset_at) reset = 1'b0;
            if (lat == reset_at + 1) reset = 1'b1;
            if (busy_c) bcnt++;
            if (done_c) seen = 1'b1;
        end
        start28 = 1'b0;
        if (reset_at > 0) begin
            nz = 0;
            for (int k = 0; k < 196; k++) if (out_c[k*16 +: 16] != 16'h0000) nz++;
            check_eq({tag, " no done after reset"}, {31'd0, seen}, 32'd0);
            check_eq({tag, " busy after reset"}, {31'd0, busy_c}, 32'd0);
            check_eq({tag, " nonzero slots after reset"}, nz, 0);
        end else begin
            check_eq({tag, " latency"}, lat, 785);
            check_eq({tag, " busy cycles"}, bcnt, 784);
            for (int i = 0; i < 14; i++)
                for (int j = 0; j < 14; j++)
                    check_eq({tag, " slot"}, {16'd0, out_c[(i*14+j)*16 +: 16]}, {16'd0, exp_slot(28, i, j, 1'b1)});
            @(negedge clk);
            check_eq({tag, " done one cycle"}, {31'd0, done_c}, 32'd0);
        end
    endtask

    initial begin
        reset   = 1'b0;
        start4  = 1'b0;
        start28 = 1'b0;
        in4     = '0;
        in28    = '0;
        repeat (3) @(negedge clk);
        check_eq("reset out4", {31'd0, (out_a == '0) && (out_b == '0)}, 32'd1);
        check_eq("reset out28", {31'd0, out_c == '0}, 32'd1);
        check_eq("reset busy", {29'd0, busy_a, busy_b, busy_c}, 32'd0);
        check_eq("reset done", {29'd0, done_a, done_b, done_c}, 32'd0);
        reset = 1'b1;

        for (int k = 0; k < 16; k++) img[k] = 16'h3800;
        img[0] = 16'h3C00; img[1] = 16'h4000; img[4] = 16'hBC00; img[5] = 16'h0000;
        run4("mixed");
        check_eq("mixed const 00", {16'd0, out_a[15:0]}, 32'h4000);
        check_eq("mixed const 11", {16'd0, out_a[63:48]}, 32'h3800);

        fill_rand(16);
        img[0] = 16'hBC00; img[1] = 16'hC000; img[4] = 16'hC400; img[5] = 16'hBE00;
        run4("allneg");
        check_eq("allneg const relu0", {16'd0, out_a[15:0]}, 32'h0000BC00);
        check_eq("allneg const relu1", {16'd0, out_b[15:0]}, 32'h0);

        img[0] = 16'h8000; img[1] = 16'h0000; img[4] = 16'h8000; img[5] = 16'h8000;
        run4("zeros");
        check_eq("zeros const", {16'd0, out_a[15:0]}, 32'h0);

        img[1] = 16'h8000;
        run4("negzero");
        check_eq("negzero const", {16'd0, out_a[15:0]}, 32'h8000);

        for (int t = 0; t < 10; t++) begin
            fill_rand(16);
            run4("rand4");
        end

        for (int k = 0; k < 784; k++) img[k] = 16'h3C00;
        run28("ones28", 0, 0);
        check_eq("ones28 const", {16'd0, out_c[16*100 +: 16]}, 32'h3C00);

        fill_rand(784);
        run28("restart28", 100, 0);

        fill_rand(784);
        run28("reset28", 0, 50);
        fill_rand(784);
        run28("fresh28", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_maxpool_relu.md
Name: conv_maxpool_relu

Overview:
- Sequential 2x2, stride-2 max-pooling stage with optional ReLU, directly downstream of the single-channel convolution layer.
- Consumes the flat 28x28 FP16 convolution output vector and produces a flat 14x14 FP16 vector for the next LeNet stage.
- Processes one comparison per clock, so area stays small and the stage pipelines behind the convolution engine.

Parameters:
- H, 28, input feature-map height (even).
- W, 28, input feature-map width (even).
- DW, 16, element width (IEEE-754 half precision).
- RELU, 1, 1 = clamp negative pooled results to 16'h0000; 0 = pass through.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset: all state cleared on a rising clk edge while reset==0.
- start  in  1  one-cycle pulse; begins pooling of inputConv.
- inputConv  in  H*W*DW  element (r,c) at bits [(r*W+c)*DW +: DW]; must be held stable while busy.
- outputPool  out  (H/2)*(W/2)*DW  element (i,j) at bits [(i*(W/2)+j)*DW +: DW].
- busy  out  1  high while pooling.
- done  out  1  one-cycle pulse when outputPool is complete.

Behaviour:
- Reset values: outputPool=0, busy=0, done=0, FSM=IDLE, all counters=0.
- Reset mid-operation: abort immediately, apply reset values, and ignore partial results.
- FSM states: IDLE, RUN, DONE.
  - IDLE: if start==1, go to RUN and set busy=1. Window counters (i,j) and phase counter p are cleared.
  - RUN, each cycle, processes window (i,j) and element p in order (2i,2j), (2i,2j+1), (2i+1,2j), (2i+1,2j+1):
    - p==0: maxReg <= elem.
    - p==1..2: maxReg <= fmax(maxReg, elem).
    - p==3: write fmax(maxReg, elem), after the ReLU step, into outputPool slot (i,j).
    - p wraps 3->0 and advances j; j wraps W/2-1 -> 0 and advances i.
    - After the last window (i=H/2-1, j=W/2-1, p=3), go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: if start is sampled at edge k, done is high in the cycle following edge k+4*(H/2)*(W/2)+1.
  - For 28x28, done asserts 785 cycles after start.
- start while busy or in DONE is ignored; no restart or queueing.
- outputPool holds its value from done until the next start. During RUN, slots update progressively and are valid only at done.
- fmax, combinational ordering:
  - key(x) = x[15] ? ~x : x ^ 16'h8000; compare keys as unsigned.
  - On equal keys, keep maxReg.
  - -0 orders below +0. NaN gets no special handling; its ordering follows the key.
- ReLU (RELU==1): if the result sign bit is 1, write 16'h0000; otherwise write the result unchanged. Applied only at write, never to the intermediate maxReg.
- No arithmetic widening; all values are DW bits.

Decomposition:
- Shared package:
  - FP16 constants: FP16_ZERO=16'h0000, FP16_SIGN_BIT=15.
  - FSM state encoding: IDLE, RUN, DONE.
  - Pooling window size constant POOL=2.
- One sub-module, fp16_max: a combinational two-input FP16 maximum implementing the key ordering above. It is reusable by later pooling layers.
- Top level holds the FSM, counters, element mux (index computation) and output register array.

Test Plan:
- H=W=4, RELU=0: window (0,0) = {3C00, 4000, BC00, 0000}, other windows all 3800.
  - Expected: outputPool slot(0,0)=4000, other three slots=3800; done 17 cycles after start.
- H=W=4: window (0,0) = {BC00, C000, C400, BE00}.
  - Expected with RELU=0: slot(0,0)=BC00. With RELU=1: slot(0,0)=0000.
- H=W=4, RELU=0: window (0,0) = {8000, 0000, 8000, 8000}.
  - Expected: slot(0,0)=0000, since +0 beats -0.
  - With all four =8000: slot(0,0)=8000.
- Default 28x28, all inputs 3C00.
  - Expected: all 196 outputs=3C00; busy high for 784 cycles; done one-cycle pulse 785 cycles after start.
- Start pulsed again at cycle 100 of a run.
  - Expected: ignored; done still at cycle 785, results unchanged.
- Reset driven low at cycle 50 of a run, then released.
  - Expected: outputPool=0, busy=0, no done pulse.
  - A fresh start then completes normally with correct values.
